// File: rtl/fc_chunk_adder_if.sv
// Chunk-stream input and sum output handshake bundle for fc_chunk_adder.
// slave = adder side, master = producer/consumer side.
interface fc_chunk_adder_if #(
   parameter int w_chunk  = 4,
   parameter int n_chunks = 2
);
   localparam int W = w_chunk * n_chunks;

   logic               up_vld;
   logic               up_rdy;
   logic [w_chunk-1:0] up_data;
   logic               down_vld;
   logic               down_rdy;
   logic [W:0]         down_data;

   modport slave (
      input  up_vld, up_data, down_rdy,
      output up_rdy, down_vld, down_data
   );

   modport master (
      output up_vld, up_data, down_rdy,
      input  up_rdy, down_vld, down_data
   );
endinterface

// File: rtl/fc_chunk_adder.sv
// Collects operand A then B as LSB-first chunks and presents the registered sum on a valid/ready port.
// Build option FC_CHUNK_ADDER_SATURATE_EN clamps the sum to w bits instead of exposing the carry.
module fc_chunk_adder #(
   parameter int w_chunk  = 4,
   parameter int n_chunks = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   fc_chunk_adder_if.slave   bus
);
   localparam int W  = w_chunk * n_chunks;
   localparam int CW = (n_chunks > 1) ? $clog2(n_chunks) : 1;
   localparam logic [CW-1:0] LAST = CW'(n_chunks - 1);

   typedef enum logic [1:0] {
      COLLECT_A = 2'd0,
      COLLECT_B = 2'd1,
      OUTPUT    = 2'd2
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  a_q;
   logic          up_rdy_q;
   logic          down_vld_q;
   logic [W:0]    down_data_q;
   logic [W-1:0]  b_full_d;
   logic [W:0]    result_d;
   logic          xfer;
   logic          last_chunk;

   // up_rdy comes straight from a register, so down_rdy never reaches it combinationally.
   assign xfer       = bus.up_vld & up_rdy_q;
   assign last_chunk = (cnt_q == LAST);

   generate
      if (n_chunks > 1) begin : g_b_lo
         logic [W-w_chunk-1:0] b_lo_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               b_lo_q <= '0;
            end else if (xfer && state_q == COLLECT_B && !last_chunk) begin
               b_lo_q[cnt_q*w_chunk +: w_chunk] <= bus.up_data;
            end
         end
         assign b_full_d = {bus.up_data, b_lo_q};
      end else begin : g_b_single
         assign b_full_d = bus.up_data;
      end
   endgenerate

   always_comb begin
      result_d = {1'b0, a_q} + {1'b0, b_full_d};
`ifdef FC_CHUNK_ADDER_SATURATE_EN
      if (result_d[W]) result_d = {1'b0, {W{1'b1}}};
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= COLLECT_A;
         cnt_q       <= '0;
         a_q         <= '0;
         up_rdy_q    <= 1'b1;
         down_vld_q  <= 1'b0;
         down_data_q <= '0;
      end else begin
         case (state_q)
            COLLECT_A: begin
               if (xfer) begin
                  a_q[cnt_q*w_chunk +: w_chunk] <= bus.up_data;
                  if (last_chunk) begin
                     cnt_q   <= '0;
                     state_q <= COLLECT_B;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            COLLECT_B: begin
               if (xfer) begin
                  if (last_chunk) begin
                     cnt_q       <= '0;
                     down_data_q <= result_d;
                     down_vld_q  <= 1'b1;
                     up_rdy_q    <= 1'b0;
                     state_q     <= OUTPUT;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            OUTPUT: begin
               // down_data_q deliberately keeps the last sum after the handshake.
               if (bus.down_rdy) begin
                  down_vld_q <= 1'b0;
                  cnt_q      <= '0;
                  up_rdy_q   <= 1'b1;
                  state_q    <= COLLECT_A;
               end
            end
            default: begin
               state_q    <= COLLECT_A;
               cnt_q      <= '0;
               down_vld_q <= 1'b0;
               up_rdy_q   <= 1'b1;
            end
         endcase
      end
   end

   assign bus.up_rdy    = up_rdy_q;
   assign bus.down_vld  = down_vld_q;
   assign bus.down_data = down_data_q;

endmodule

// File: tb/tb_fc_chunk_adder.sv
// Scoreboard bench for fc_chunk_adder (w_chunk=4, n_chunks=2); honours FC_CHUNK_ADDER_SATURATE_EN.
module tb_fc_chunk_adder;
   localparam int WC = 4;
   localparam int NC = 2;
   localparam int W  = WC * NC;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fc_chunk_adder_if #(.w_chunk(WC), .n_chunks(NC)) bus();

   fc_chunk_adder #(.w_chunk(WC), .n_chunks(NC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [W:0] exp_q[$];
   int         xfer_log[$];
   logic [W:0] mon_e;
   logic [W:0] seen;
   logic [W:0] held;
   logic [W:0] carry_exp;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
`ifdef FC_CHUNK_ADDER_SATURATE_EN
      if (s[W]) s = {1'b0, {W{1'b1}}};
`endif
      return s;
   endfunction

   // Scoreboard: compare each sum on the cycle its handshake completes.
   always @(negedge clk) begin
      if (rst_n && bus.down_vld && bus.down_rdy) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_data", 32'(bus.down_data), 32'(mon_e));
         end
      end
   end

   task automatic send_chunk(input logic [WC-1:0] d);
      int n;
      n = 0;
      @(negedge clk);
      bus.up_vld  = 1'b1;
      bus.up_data = d;
      while (!bus.up_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("xfer_timeout", 32'd0, 32'd1);
      xfer_log.push_back(cyc);
      @(posedge clk);
   endtask

   task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b, input bit bubble,
                            input bit chk_lat, input bit chk_rdy, output logic [W:0] got);
      logic [W:0]   e;
      logic [W-1:0] op;
      e = model(a, b);
      exp_q.push_back(e);
      got = '0;
      for (int i = 0; i < 2*NC; i++) begin
         op = (i < NC) ? a : b;
         send_chunk(op[(i%NC)*WC +: WC]);
         if (bubble && i < 2*NC-1) begin
            @(negedge clk);
            bus.up_vld  = 1'b0;
            bus.up_data = WC'($urandom);
         end
      end
      if (chk_lat) begin
         @(negedge clk);
         check("lat_vld", 32'(bus.down_vld), 32'd1);
         check("lat_rdy", 32'(bus.up_rdy), 32'd0);
         check("lat_data", 32'(bus.down_data), 32'(e));
         got = bus.down_data;
         if (!chk_rdy) begin
            bus.up_vld = 1'b0;
         end else begin
            @(negedge clk);
            check("rdy_back", 32'(bus.up_rdy), 32'd1);
            check("vld_clr", 32'(bus.down_vld), 32'd0);
            bus.up_vld = 1'b0;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef FC_CHUNK_ADDER_SATURATE_EN
      carry_exp = 9'h0FF;
`else
      carry_exp = 9'h101;
`endif
      bus.up_vld   = 1'b0;
      bus.up_data  = '0;
      bus.down_rdy = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_up_rdy", 32'(bus.up_rdy), 32'd1);
      check("rst_down_vld", 32'(bus.down_vld), 32'd0);
      check("rst_down_data", 32'(bus.down_data), 32'd0);
      rst_n = 1'b1;

      send_pair(8'h3C, 8'h0F, 1'b0, 1'b1, 1'b1, seen);
      check("basic_sum", 32'(seen), 32'h04B);

      send_pair(8'hFF, 8'h02, 1'b0, 1'b1, 1'b1, seen);
      check("carry_sum", 32'(seen), 32'(carry_exp));

      // Backpressure: sum must sit still and inputs stay blocked.
      @(posedge clk);
      #2 bus.down_rdy = 1'b0;
      send_pair(8'h5A, 8'hC3, 1'b0, 1'b1, 1'b0, seen);
      held = seen;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_vld", 32'(bus.down_vld), 32'd1);
         check("bp_data", 32'(bus.down_data), 32'(held));
         check("bp_rdy", 32'(bus.up_rdy), 32'd0);
         bus.up_vld  = (i % 2 == 0);
         bus.up_data = WC'($urandom);
      end
      @(posedge clk);
      #2;
      bus.down_rdy = 1'b1;
      bus.up_vld   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("bp_vld_clr", 32'(bus.down_vld), 32'd0);
      check("bp_rdy_back", 32'(bus.up_rdy), 32'd1);
      check("bp_keep_data", 32'(bus.down_data), 32'(held));

      send_pair(8'h12, 8'h34, 1'b1, 1'b1, 1'b1, seen);
      check("bubble_sum", 32'(seen), 32'h046);

      // Back-to-back with up_vld held high throughout.
      xfer_log.delete();
      send_pair(8'hA5, 8'h5A, 1'b0, 1'b0, 1'b0, seen);
      send_pair(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, seen);
      send_pair(8'h80, 8'h01, 1'b0, 1'b0, 1'b0, seen);
      @(negedge clk);
      bus.up_vld = 1'b0;
      check("b2b_xfers", 32'(xfer_log.size()), 32'd12);
      check("b2b_span", 32'(xfer_log[xfer_log.size()-1] - xfer_log[0]), 32'd13);

      // Asynchronous reset in the middle of operand B.
      repeat (2) @(negedge clk);
      send_chunk(4'h7);
      send_chunk(4'h7);
      send_chunk(4'h9);
      #3;
      rst_n      = 1'b0;
      bus.up_vld = 1'b0;
      #1;
      check("arst_down_vld", 32'(bus.down_vld), 32'd0);
      check("arst_down_data", 32'(bus.down_data), 32'd0);
      check("arst_up_rdy", 32'(bus.up_rdy), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      send_pair(8'h01, 8'h01, 1'b0, 1'b1, 1'b1, seen);
      check("post_rst_sum", 32'(seen), 32'h002);

      repeat (3) @(negedge clk);
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fc_chunk_adder.md
Name: fc_chunk_adder

Overview:
- Flow-controlled adder front end. Collects operand A, then operand B, from a narrow valid/ready chunk stream, LSB chunk first.
- Registers A+B and presents it on a valid/ready output that drives the flow-controlled pipeline register directly downstream.
- up_rdy is a function of registered state only. This block adds no combinational down_rdy -> up_rdy path to the chain.

Parameters:
- w_chunk, 4, width of one input chunk.
- n_chunks, 2, chunks per operand (>= 1). Operand width w = w_chunk * n_chunks.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- up_vld  input  1  input chunk valid.
- up_rdy  output  1  block accepts a chunk this cycle.
- up_data  input  w_chunk  input chunk.
- down_vld  output  1  sum valid.
- down_rdy  input  1  downstream accepts the sum.
- down_data  output  w+1  sum, MSB is carry-out.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - state = COLLECT_A, chunk counter = 0.
  - A register = 0, down_vld = 0, down_data = 0.
- Reset mid-operation discards all partial operands and any pending sum. After release, the first accepted chunk is A chunk 0.
- Chunk transfer occurs on an edge with up_vld & up_rdy. up_rdy = 1 in COLLECT_A and COLLECT_B, 0 in OUTPUT.
- Counter: 0..n_chunks-1, increments per transfer, wraps to 0 on the last chunk of an operand.
- Chunk i is written to bits [i*w_chunk +: w_chunk] of the current operand.
- COLLECT_A:
  - Each transfer stores the chunk into A.
  - On the transfer with counter = n_chunks-1, go to COLLECT_B.
- COLLECT_B:
  - Lower B chunks go into a B register.
  - On the last B transfer, on that same edge:
    - down_data <= A + {incoming chunk, B lower chunks}, zero-extended to w+1 bits.
    - down_vld <= 1, go to OUTPUT.
  - Latency: last B chunk accepted at edge k -> down_vld = 1 after edge k.
- OUTPUT:
  - down_data and down_vld are held stable while down_rdy = 0.
  - On an edge with down_rdy = 1: down_vld <= 0, counter = 0, state -> COLLECT_A. up_rdy = 1 from the next cycle.
  - Throughput is one sum per 2*n_chunks+1 cycles minimum.
- up_data is ignored when up_vld = 0 or up_rdy = 0. No state changes on non-transfer cycles.
- n_chunks = 1:
  - Each operand is a single transfer.
  - COLLECT_A -> COLLECT_B after one chunk; COLLECT_B -> OUTPUT after one chunk.
- down_data changes only on the edge that loads a new sum or on reset. It keeps its old value after the handshake.
- Arithmetic: unsigned, full precision. Maximum sum 2*(2^w - 1) fits in w+1 bits.
- Unused state encoding goes to COLLECT_A with down_vld = 0.

Optional Feature:
- Macro FC_CHUNK_ADDER_SATURATE_EN.
- Defined: the result is saturated to w bits.
  - If the carry-out is 1, down_data[w-1:0] = all ones.
  - down_data[w] is always 0.
- Not defined: down_data carries the full w+1-bit sum including carry.
- Timing and handshake are identical in both builds.

Test Plan (w_chunk=4, n_chunks=2):
- Basic sum, down_rdy held 1:
  - Stimulus: A chunks C,3 (0x3C), then B chunks F,0 (0x0F).
  - Response: down_vld = 1 one edge after the 4th transfer, down_data = 0x04B. up_rdy = 0 for exactly one cycle.
- Carry and saturation:
  - Stimulus: A = 0xFF, B = 0x02.
  - Response: down_data = 0x101 without the macro. With FC_CHUNK_ADDER_SATURATE_EN: down_data = 0x0FF.
- Backpressure:
  - Stimulus: down_rdy = 0 for 5 cycles after the sum appears.
  - Response: down_vld = 1 and down_data constant for all 5 cycles; up_rdy = 0 throughout; up_vld pulses are ignored. Raising down_rdy completes the transfer; up_rdy = 1 on the next cycle.
- Bubbles:
  - Stimulus: up_vld toggled 1,0,1,0 between chunks of A = 0x12, B = 0x34.
  - Response: only valid chunks are captured; down_data = 0x046.
- Reset mid-operation:
  - Stimulus: after A fully sent and one B chunk sent, assert rst_n low asynchronously (mid-cycle).
  - Response: down_vld = 0 and down_data = 0 immediately. Next operands A = 0x01, B = 0x01 give 0x002.
- Back-to-back, with down_rdy = 1 and up_vld = 1 continuously:
  - Stimulus: three operand pairs.
  - Response: three sums, each on the edge after its final B chunk, one cycle of up_rdy = 0 between pairs; no chunk lost or duplicated.
